// File: rtl/accum_frame_if.sv
// accum_frame_if: operand stream (din/din_valid/din_ready/len) and result
// stream (dout/dout_valid/dout_ready/dout_ovf) of the frame accumulator.
// The master side produces operands and consumes results; the slave side is
// the accumulator itself.
interface accum_frame_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int LEN_WIDTH  = 4
);
    logic [DATA_WIDTH-1:0] din;
    logic                  din_valid;
    logic                  din_ready;
    logic [LEN_WIDTH-1:0]  len;
    logic [ACC_WIDTH-1:0]  dout;
    logic                  dout_valid;
    logic                  dout_ready;
    logic                  dout_ovf;

    modport master (
        output din, din_valid, len, dout_ready,
        input  din_ready, dout, dout_valid, dout_ovf
    );

    modport slave (
        input  din, din_valid, len, dout_ready,
        output din_ready, dout, dout_valid, dout_ovf
    );
endinterface

// File: rtl/accum_frame.sv
// accum_frame: sums a programmable number of unsigned operand beats per frame
// and presents one registered result per frame with a sticky carry flag.
// Optional macro ACCUM_SATURATE_EN: once a carry has occurred in a frame the
// accumulator clamps to all ones; without it the sum wraps modulo 2^ACC_WIDTH.
module accum_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int LEN_WIDTH  = 4
) (
    input  logic             clk,
    input  logic             reset,
    accum_frame_if.slave     bus
);

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [ACC_WIDTH-1:0]  dout_q, dout_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic                  ovf_q, ovf_d;
    logic                  dout_ovf_q, dout_ovf_d;

    logic                  beat_fire;
    logic                  res_fire;
    logic                  first_beat;
    logic                  last_beat;
    logic [LEN_WIDTH-1:0]  len_eff;
    logic [ACC_WIDTH-1:0]  acc_base;
    logic [ACC_WIDTH-1:0]  sum;
    logic                  carry;
    logic                  ovf_new;
    logic [ACC_WIDTH-1:0]  acc_next;

    // Zero-extended widening add; the extra top bit is the carry out of the accumulator.
    function automatic logic [ACC_WIDTH:0] add_wide(
        input logic [ACC_WIDTH-1:0]  a,
        input logic [DATA_WIDTH-1:0] b
    );
        add_wide = {1'b0, a} + {{(ACC_WIDTH + 1 - DATA_WIDTH){1'b0}}, b};
    endfunction

`ifdef ACCUM_SATURATE_EN
    // Clamp to full scale once the frame has overflowed.
    function automatic logic [ACC_WIDTH-1:0] clamp_acc(
        input logic [ACC_WIDTH-1:0] v,
        input logic                 ovf
    );
        clamp_acc = ovf ? {ACC_WIDTH{1'b1}} : v;
    endfunction
`endif

    assign bus.din_ready  = (state_q == ST_ACC) && !reset;
    assign bus.dout_valid = (state_q == ST_OUT);
    assign bus.dout       = dout_q;
    assign bus.dout_ovf   = dout_ovf_q;

    assign beat_fire  = bus.din_valid && bus.din_ready;
    assign res_fire   = bus.dout_valid && bus.dout_ready;
    assign first_beat = (cnt_q == '0);

    // Datapath: effective frame length, the add, carry tracking and last-beat detect.
    always_comb begin
        len_eff  = len_q;
        acc_base = acc_q;
        if (first_beat) begin
            len_eff  = (bus.len == '0) ? LEN_WIDTH'(1) : bus.len;
            acc_base = '0;
        end
        {carry, sum} = add_wide(acc_base, bus.din);
        ovf_new      = (first_beat ? 1'b0 : ovf_q) | carry;
`ifdef ACCUM_SATURATE_EN
        acc_next     = clamp_acc(sum, ovf_new);
`else
        acc_next     = sum;
`endif
        last_beat    = ((cnt_q + LEN_WIDTH'(1)) == len_eff);
    end

    // Next-state logic: accumulate beats in ACC, hold the result in OUT until taken.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        ovf_d      = ovf_q;
        dout_d     = dout_q;
        dout_ovf_d = dout_ovf_q;
        case (state_q)
            ST_ACC: begin
                if (beat_fire) begin
                    acc_d = acc_next;
                    cnt_d = cnt_q + LEN_WIDTH'(1);
                    ovf_d = ovf_new;
                    if (first_beat) begin
                        len_d = len_eff;
                    end
                    if (last_beat) begin
                        dout_d     = acc_next;
                        dout_ovf_d = ovf_new;
                        state_d    = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                if (res_fire) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_ACC;
            acc_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            ovf_q      <= 1'b0;
            dout_q     <= '0;
            dout_ovf_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            ovf_q      <= ovf_d;
            dout_q     <= dout_d;
            dout_ovf_q <= dout_ovf_d;
        end
    end

endmodule

// File: tb/tb_accum_frame.sv
// tb_accum_frame: table-driven frames, hand-written corner sequences and
// randomized frames checked against a whole-frame arithmetic model.
// Honors ACCUM_SATURATE_EN for the expected results.
module tb_accum_frame;

    localparam int DW = 8;
    localparam int AW = 10;
    localparam int LW = 4;
    localparam int FULL = 1 << AW;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    accum_frame_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    accum_frame #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [LW-1:0] len;
        int            n;
        logic [7:0]    base;
        logic [7:0]    step;
        logic [AW-1:0] exp_dout;
        logic          exp_ovf;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Present one beat and return on the falling edge after it was accepted.
    task automatic send_beat(input logic [7:0] d);
        int guard;
        guard = 0;
        bus.din       = d;
        bus.din_valid = 1'b1;
        while (bus.din_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("beat_accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.din_valid = 1'b0;
    endtask

    // Called right after the last beat: result must already be valid; hold it, then take it.
    task automatic take_result(input string name, input logic [AW-1:0] exp_dout,
                               input logic exp_ovf, input int delay);
        logic [AW-1:0] held;
        chk({name, "_valid"}, 32'(bus.dout_valid), 32'd1);
        chk({name, "_dout"},  32'(bus.dout), 32'(exp_dout));
        chk({name, "_ovf"},   32'(bus.dout_ovf), 32'(exp_ovf));
        held = bus.dout;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk({name, "_hold_dout"},  32'(bus.dout), 32'(held));
            chk({name, "_hold_ovf"},   32'(bus.dout_ovf), 32'(exp_ovf));
            chk({name, "_hold_ready"}, 32'(bus.din_ready), 32'd0);
        end
        bus.dout_ready = 1'b1;
        @(negedge clk);
        bus.dout_ready = 1'b0;
        chk({name, "_taken"},   32'(bus.dout_valid), 32'd0);
        chk({name, "_retain"},  32'(bus.dout), 32'(held));
        chk({name, "_reopen"},  32'(bus.din_ready), 32'd1);
    endtask

    function automatic logic [AW-1:0] model_dout(input int total);
`ifdef ACCUM_SATURATE_EN
        return (total >= FULL) ? AW'(FULL - 1) : AW'(total);
`else
        return AW'(total % FULL);
`endif
    endfunction

    initial begin
        logic [7:0] b;
        int         leff;
        int         total;
        int         mode;

        errors = 0;
        checks = 0;
        reset          = 1'b1;
        bus.din        = '0;
        bus.din_valid  = 1'b0;
        bus.len        = '0;
        bus.dout_ready = 1'b0;

        // Vectors: len, beats, first beat, beat increment, expected sum, expected carry flag.
        tbl[0] = '{4'd3,  3, 8'h10, 8'h10, 10'h060, 1'b0};
`ifdef ACCUM_SATURATE_EN
        tbl[1] = '{4'd5,  5, 8'hFF, 8'h00, 10'h3FF, 1'b1};
        tbl[5] = '{4'd8,  8, 8'h80, 8'h00, 10'h3FF, 1'b1};
`else
        tbl[1] = '{4'd5,  5, 8'hFF, 8'h00, 10'h0FB, 1'b1};
        tbl[5] = '{4'd8,  8, 8'h80, 8'h00, 10'h000, 1'b1};
`endif
        tbl[2] = '{4'd0,  1, 8'hA5, 8'h00, 10'h0A5, 1'b0};
        tbl[3] = '{4'd1,  1, 8'h00, 8'h00, 10'h000, 1'b0};
        tbl[4] = '{4'd4,  4, 8'hFF, 8'h00, 10'h3FC, 1'b0};
        tbl[6] = '{4'd15, 15, 8'h44, 8'h00, 10'h3FC, 1'b0};
        tbl[7] = '{4'd4,  4, 8'h01, 8'h40, 10'h184, 1'b0};

        // Reset state.
        @(negedge clk);
        chk("rst_din_ready",  32'(bus.din_ready), 32'd0);
        chk("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
        chk("rst_dout",       32'(bus.dout), 32'd0);
        chk("rst_dout_ovf",   32'(bus.dout_ovf), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_din_ready", 32'(bus.din_ready), 32'd1);

        // Table-driven frames, beats back-to-back.
        for (int v = 0; v < 8; v++) begin
            bus.len = tbl[v].len;
            for (int k = 0; k < tbl[v].n; k++) begin
                b = tbl[v].base + 8'(k) * tbl[v].step;
                send_beat(b);
                if (k < tbl[v].n - 1) chk($sformatf("tbl%0d_early_valid", v), 32'(bus.dout_valid), 32'd0);
            end
            take_result($sformatf("tbl%0d", v), tbl[v].exp_dout, tbl[v].exp_ovf, v % 3);
        end

        // Output back-pressure with the next beat already waiting.
        bus.len = 4'd1;
        send_beat(8'h3C);
        bus.din       = 8'h77;
        bus.din_valid = 1'b1;
        take_result("stall", 10'h03C, 1'b0, 4);
        @(negedge clk);
        bus.din_valid = 1'b0;
        take_result("stall_next", 10'h077, 1'b0, 0);

        // Length changes mid-frame are ignored; the next frame picks up the new length.
        bus.len = 4'd2;
        send_beat(8'h01);
        bus.len = 4'd7;
        send_beat(8'h02);
        take_result("lenchg", 10'h003, 1'b0, 0);
        for (int k = 0; k < 7; k++) begin
            send_beat(8'h01);
            if (k == 1) chk("lenchg_next_not_done", 32'(bus.dout_valid), 32'd0);
        end
        take_result("lenchg_next", 10'h007, 1'b0, 1);

        // Reset mid-frame: outputs clear immediately, partial sum is dropped.
        bus.len = 4'd4;
        send_beat(8'h33);
        send_beat(8'h33);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_din_ready",  32'(bus.din_ready), 32'd0);
        chk("midrst_dout_valid", 32'(bus.dout_valid), 32'd0);
        chk("midrst_dout",       32'(bus.dout), 32'd0);
        chk("midrst_dout_ovf",   32'(bus.dout_ovf), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) send_beat(8'h05);
        take_result("postrst", 10'h014, 1'b0, 0);

        // Randomized frames against a whole-frame sum model.
        for (int f = 0; f < 40; f++) begin
            bus.len = LW'($urandom_range(0, 15));
            leff    = (bus.len == 0) ? 1 : int'(bus.len);
            mode    = $urandom_range(0, 2);
            total   = 0;
            for (int k = 0; k < leff; k++) begin
                case (mode)
                    0:       b = 8'($urandom_range(0, 31));
                    1:       b = 8'($urandom_range(0, 255));
                    default: b = 8'($urandom_range(200, 255));
                endcase
                total += int'(b);
                repeat ($urandom_range(0, 2)) begin
                    bus.din = 8'($urandom);
                    @(negedge clk);
                end
                send_beat(b);
            end
            take_result($sformatf("rnd%0d", f), model_dout(total), (total >= FULL),
                        $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
